// File: rtl/led_fade_sched.sv
// led_fade_sched: shared-timebase PWM for NCH LEDs with a round-robin
// target-update arbiter and a per-frame fade engine.
//
// Ports:
//   sysclk      - sole clock
//   rst         - asynchronous active-high reset
//   enable      - global output enable (gates pwm_out only)
//   fade_step   - duty change per frame, 0 = jump to target
//   req         - per-channel target-update request (held until grant)
//   req_duty    - per-channel requested duty, channel i at [6i+5:6i]
//   grant       - one-hot single-cycle acknowledge of the accepted request
//   pwm_out     - registered PWM output per channel
//   busy        - registered: some channel's duty differs from its target
//   frame_start - pulse on the tick where the PWM counter wraps 63->0

module led_fade_sched #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 2
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       fade_step,
    input  logic [NCH-1:0]   req,
    input  logic [6*NCH-1:0] req_duty,
    output logic [NCH-1:0]   grant,
    output logic [NCH-1:0]   pwm_out,
    output logic             busy,
    output logic             frame_start
);

    localparam int PSW = $clog2(PRESCALE);
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PSW-1:0] presc;
    logic [5:0]     cnt;
    logic           tick;
    logic [5:0]     cur [NCH];
    logic [5:0]     tgt [NCH];
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  gidx;
    logic [PW-1:0]  ptr_nxt;
    logic [PW:0]    sum;
    logic [PW-1:0]  idx;
    logic           found;
    logic           any_diff;

    // Saturating move of c toward t by s; the 7-bit intermediates
    // expose overshoot past the target and borrow below zero.
    function automatic logic [5:0] fade(
        input logic [5:0] c,
        input logic [5:0] t,
        input logic [2:0] s
    );
        logic [6:0] up;
        logic [6:0] dn;
        up = {1'b0, c} + {4'b0, s};
        dn = {1'b0, c} - {4'b0, s};
        if (s == 3'd0) return t;
        if (c < t) return (up >= {1'b0, t}) ? t : up[5:0];
        if (c > t) return (dn[6] || dn[5:0] <= t) ? t : dn[5:0];
        return c;
    endfunction

    assign tick        = (presc == PSW'(PRESCALE - 1));
    assign frame_start = !rst && tick && (cnt == 6'd63);

    // Round-robin search starting at ptr (the channel after the last grant).
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && !rst) grant[gidx] = 1'b1;
    end

    assign ptr_nxt = (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (cur[i] != tgt[i]) any_diff = 1'b1;
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            cnt     <= '0;
            ptr     <= '0;
            pwm_out <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cur[i] <= '0;
                tgt[i] <= '0;
            end
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
            if (found) ptr <= ptr_nxt;
            busy <= any_diff;
            for (int i = 0; i < NCH; i++) begin
                pwm_out[i] <= enable && (cnt < cur[i]);
                // Fade uses the pre-edge target, so a grant landing on
                // frame_start only takes effect one frame later.
                if (frame_start)
                    cur[i] <= fade(cur[i], tgt[i], fade_step);
                if (grant[i])
                    tgt[i] <= req_duty[6*i +: 6];
            end
        end
    end

endmodule

// File: doc/led_fade_sched.md
LED_FADE_SCHED -- requirements
Module: led_fade_sched

Interface
REQ-001 Parameter NCH, default 4: number of LED channels sharing the PWM timebase.
REQ-002 Parameter PRESCALE, default 2: sysclk cycles per PWM tick; legal range 2..255.
REQ-003 sysclk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 enable  input  1  global output enable; low forces all pwm_out low.
REQ-006 fade_step  input  3  duty increment per PWM frame; 0 = jump straight to target.
REQ-007 req  input  NCH  per-channel target-update request; held high by the requester until its grant.
REQ-008 req_duty  input  6*NCH  per-channel requested target duty; channel i uses bits [6i+5:6i].
REQ-009 grant  output  NCH  one-hot, single-cycle acknowledge of the accepted request.
REQ-010 pwm_out  output  NCH  registered PWM output per channel.
REQ-011 busy  output  1  high while any channel's current duty differs from its target.
REQ-012 frame_start  output  1  single-cycle pulse on the tick where the PWM counter wraps 63->0.

Function
REQ-013 Prescaler counts 0..PRESCALE-1 and asserts an internal tick for one sysclk cycle when it wraps to 0.
REQ-014 The 6-bit PWM counter increments only on tick and wraps 63->0; one frame = 64*PRESCALE sysclk cycles.
REQ-015 frame_start is asserted in the cycle where the counter goes from 63 to 0.
REQ-016 pwm_out[i] is registered as enable AND (counter < cur_duty[i]); duty 0 gives constant low, duty 63 gives 63/64 high.
REQ-017 Arbiter: at most one grant per sysclk cycle, round-robin, searching from the channel after the last granted one; after reset the search starts at channel 0.
REQ-018 On grant[i], target[i] is loaded from req_duty slice i in the same edge; grant is never asserted to a channel whose req is low.
REQ-019 A channel whose req stays high is re-granted at most once per NCH cycles while other requests are pending; with all NCH requesting, grants rotate 0,1,2,...,NCH-1,0.
REQ-020 Fade engine updates cur_duty only on the frame_start cycle, so no PWM period contains a mid-frame duty change.
REQ-021 On frame_start, cur<target: cur += fade_step, saturating at target; cur>target: cur -= fade_step, saturating at target; no wrap or overshoot; 6-bit arithmetic using a 7-bit intermediate.
REQ-022 fade_step = 0: cur_duty[i] becomes target[i] on the next frame_start.
REQ-023 Grant and frame_start in the same cycle: the fade step uses the old target; the new target applies from the next frame.
REQ-024 busy is the registered OR over channels of (cur_duty != target); it settles one cycle after the last change.
REQ-025 enable low does not stop the prescaler, counter, arbiter or fade engine; only pwm_out is gated.
REQ-026 fade_step is sampled on each frame_start; a change mid-frame takes effect at the next frame boundary.

Reset
REQ-027 rst high clears the prescaler, counter, all cur_duty and target, and the arbiter pointer to channel 0, asynchronously.
REQ-028 While rst is high: pwm_out = 0, grant = 0, busy = 0, frame_start = 0.
REQ-029 Asserting rst mid-fade or mid-grant discards all state; after release the first tick occurs PRESCALE cycles later.

Verification
REQ-030 Reset, then req[0]=1 with duty 40 and fade_step=0 -> grant[0] the next cycle; after the next frame_start, pwm_out[0] high for 40 of every 64 ticks; busy drops.
REQ-031 All four req high with distinct duties -> grants 0,1,2,3 in four consecutive cycles, each one-hot; targets match req_duty.
REQ-032 Channel 1 target 63 from 0 with fade_step=5 -> cur steps 5,10,...,60,63 on 13 consecutive frames; busy is high throughout and low after the 63 step.
REQ-033 Target 0 from 63 with fade_step=7 -> cur steps 56,...,7,0 with no underflow; pwm_out constant low afterwards.
REQ-034 Grant issued in the same cycle as frame_start -> that frame's step uses the old target; the new target is seen one frame later.
REQ-035 enable toggled low mid-fade, then rst pulsed mid-frame -> pwm_out low immediately with the fade still progressing; after rst all outputs are 0 and the first tick comes PRESCALE cycles after release.
